i2c_bus_monitor: RTL and testbench

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

---
 rtl/i2c_pkg.sv | 6 +
 rtl/i2c_glitch_filter.sv | 29 ++
 rtl/i2c_bus_monitor.sv | 93 +++++++++
 tb/tb_i2c_bus_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths and FSM state type for the I2C bus monitor
package i2c_pkg;
  localparam int TMO_W_DEF = 16;
  localparam int FILT_W_DEF = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ACK} state_t;
endpackage

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: two-flop synchronizer plus persistence filter for one bus line
module i2c_glitch_filter #(
  parameter int FILT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pad_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              filt_o
);
  logic s1, s2;
  logic [FILT_W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      filt_o <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= pad_i;
      s2 <= s1;
      if (s2 == filt_o) cnt <= '0;
      else if (cnt == filt_len_i) begin
        filt_o <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C observer reporting START/STOP, received bytes and SCL-low timeouts
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              enable_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [TMO_W-1:0]  timeout_i,
  output logic              scl_filt_o,
  output logic              sda_filt_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              busy_o,
  output logic              byte_valid_o,
  output logic [7:0]        byte_o,
  output logic              ack_o,
  output logic              timeout_o
);
  state_t state;
  logic scl_q, sda_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [TMO_W-1:0] tmo_cnt;
  logic scl_rise, start_det, stop_det, tmo_hit;
  i2c_glitch_filter #(.FILT_W(FILT_W)) u_scl (
    .clk_i(clk_i), .rst_i(rst_i), .pad_i(scl_i), .filt_len_i(filt_len_i), .filt_o(scl_filt_o)
  );
  i2c_glitch_filter #(.FILT_W(FILT_W)) u_sda (
    .clk_i(clk_i), .rst_i(rst_i), .pad_i(sda_i), .filt_len_i(filt_len_i), .filt_o(sda_filt_o)
  );
  // SCL must be high in both samples, so an SDA edge coincident with an SCL edge is never START/STOP
  assign scl_rise = scl_filt_o & ~scl_q;
  assign start_det = scl_filt_o & scl_q & sda_q & ~sda_filt_o;
  assign stop_det = scl_filt_o & scl_q & ~sda_q & sda_filt_o;
  assign tmo_hit = busy_o && timeout_i != '0 && tmo_cnt == timeout_i;
  assign busy_o = state != ST_IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      state <= ST_IDLE;
      bit_cnt <= '0;
      shift <= '0;
      tmo_cnt <= '0;
      start_o <= 1'b0;
      stop_o <= 1'b0;
      byte_valid_o <= 1'b0;
      timeout_o <= 1'b0;
      byte_o <= 8'h00;
      ack_o <= 1'b1;
    end else begin
      scl_q <= scl_filt_o;
      sda_q <= sda_filt_o;
      start_o <= 1'b0;
      stop_o <= 1'b0;
      byte_valid_o <= 1'b0;
      timeout_o <= 1'b0;
      tmo_cnt <= (!enable_i || !busy_o || scl_filt_o) ? '0 : tmo_cnt + TMO_W'(!(&tmo_cnt));
      // a STOP seen while idle (e.g. after a timeout) belongs to a transfer we are not tracking
      if (!enable_i) begin
        state <= ST_IDLE;
        bit_cnt <= '0;
      end else if (stop_det) begin
        stop_o <= busy_o;
        state <= ST_IDLE;
      end else if (start_det) begin
        start_o <= 1'b1;
        state <= ST_DATA;
        bit_cnt <= '0;
        shift <= '0;
      end else if (tmo_hit) begin
        timeout_o <= 1'b1;
        state <= ST_IDLE;
      end else if (scl_rise && state == ST_DATA) begin
        shift <= {shift[6:0], sda_filt_o};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state <= ST_ACK;
      end else if (scl_rise && state == ST_ACK) begin
        byte_o <= shift;
        ack_o <= sda_filt_o;
        byte_valid_o <= 1'b1;
        bit_cnt <= '0;
        state <= ST_DATA;
      end
    end
  end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: directed bus scenarios checked against a behavioural bus model
module tb_i2c_bus_monitor;
  localparam int TW = 16;
  localparam int FW = 4;
  localparam int H = 10;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1, en = 1'b1;
  logic [FW-1:0] flen = 4'd3;
  logic [TW-1:0] tmo = '0;
  logic scl_f, sda_f, start_o, stop_o, busy_o, bv_o, ack_o, tmo_o;
  logic [7:0] byte_o;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk = 1'b0;
  i2c_bus_monitor #(.TMO_W(TW), .FILT_W(FW)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .enable_i(en),
    .filt_len_i(flen), .timeout_i(tmo), .scl_filt_o(scl_f), .sda_filt_o(sda_f),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o), .byte_valid_o(bv_o),
    .byte_o(byte_o), .ack_o(ack_o), .timeout_o(tmo_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // behavioural model: lines follow the pads once they differ for flen+1 synced cycles;
  // the protocol view keeps the bits of the current frame in a queue
  bit m_s1[2], m_s2[2], m_f[2], m_p[2];
  int m_run[2];
  bit m_busy, m_ack, e_start, e_stop, e_bv, e_tmo;
  bit mq[$];
  int m_low;
  logic [7:0] m_byte;

  task automatic model_step();
    bit rise, st, sp, hit, bo;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1; m_s2[k] = 1; m_f[k] = 1; m_p[k] = 1; m_run[k] = 0;
      end
      m_busy = 0; m_low = 0; mq.delete();
      {e_start, e_stop, e_bv, e_tmo} = '0;
      m_byte = 8'h00; m_ack = 1;
      return;
    end
    rise = m_f[0] && !m_p[0];
    st = m_f[0] && m_p[0] && m_p[1] && !m_f[1];
    sp = m_f[0] && m_p[0] && !m_p[1] && m_f[1];
    hit = m_busy && tmo != 0 && m_low == int'(tmo);
    bo = m_busy;
    {e_start, e_stop, e_bv, e_tmo} = '0;
    if (!en) begin m_busy = 0; mq.delete(); end
    else if (sp) begin e_stop = bo; m_busy = 0; end
    else if (st) begin e_start = 1; m_busy = 1; mq.delete(); end
    else if (hit) begin e_tmo = 1; m_busy = 0; end
    else if (rise && m_busy) begin
      mq.push_back(m_f[1]);
      if (mq.size() == 9) begin
        m_byte = 0;
        for (int i = 0; i < 8; i++) m_byte = m_byte * 2 + 8'(mq[i]);
        m_ack = mq[8]; e_bv = 1; mq.delete();
      end
    end
    m_low = (!en || !bo || m_f[0]) ? 0 : (m_low == 65535 ? m_low : m_low + 1);
    for (int k = 0; k < 2; k++) begin
      m_p[k] = m_f[k];
      if (m_s2[k] != m_f[k]) begin
        m_run[k]++;
        if (m_run[k] == int'(flen) + 1) begin m_f[k] = m_s2[k]; m_run[k] = 0; end
      end else m_run[k] = 0;
      m_s2[k] = m_s1[k];
      m_s1[k] = (k == 0) ? scl : sda;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int n_start, n_stop, n_bv, n_tmo, n_fall;
  logic [8:0] got[$];
  bit busy_d;
  always @(negedge clk) begin
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (tmo_o) n_tmo++;
    if (busy_d && !busy_o) n_fall++;
    busy_d = busy_o;
    if (bv_o) begin n_bv++; got.push_back({ack_o, byte_o}); end
    if (chk) begin
      check("scl_filt", scl_f, m_f[0]);
      check("sda_filt", sda_f, m_f[1]);
      check("start", start_o, e_start);
      check("stop", stop_o, e_stop);
      check("busy", busy_o, m_busy);
      check("byte_valid", bv_o, e_bv);
      check("byte", byte_o, m_byte);
      check("ack", ack_o, m_ack);
      check("timeout", tmo_o, e_tmo);
    end
  end

  task automatic clr();
    #2;
    n_start = 0; n_stop = 0; n_bv = 0; n_tmo = 0; n_fall = 0; got.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c();
    sda = 1; idle(H); scl = 1; idle(H); sda = 0; idle(H); scl = 0; idle(H);
  endtask
  task automatic bit_c(input bit b);
    sda = b; idle(H); scl = 1; idle(H); scl = 0; idle(H);
  endtask
  task automatic stop_c();
    sda = 0; idle(H); scl = 1; idle(H); sda = 1; idle(H);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit a);
    for (int i = 7; i >= 0; i--) bit_c(b[i]);
    bit_c(a);
  endtask

  initial begin
    int t0, lat;
    idle(3);
    chk = 1;
    check("rst_busy", busy_o, 0);
    check("rst_byte", byte_o, 0);
    check("rst_ack", ack_o, 1);
    check("rst_scl_filt", scl_f, 1);
    rst = 0;
    idle(10);
    // glitch rejection and START latency
    clr();
    sda = 0; idle(3); sda = 1; idle(20);
    #2 check("glitch_start_cnt", n_start, 0);
    @(negedge clk);
    sda = 0; t0 = cyc; lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (start_o) lat = cyc - t0;
    end
    check("start_latency", lat, 7);
    idle(H); sda = 1; idle(20);
    #2 check("first_stop_cnt", n_stop, 1);
    // full two-byte transfer
    clr();
    start_c(); send_byte(8'hA5, 0); send_byte(8'h3C, 1); stop_c(); idle(H);
    #2;
    check("xfer_nbytes", got.size(), 2);
    check("xfer_byte0", got.size() > 0 ? int'(got[0]) : -1, 9'h0A5);
    check("xfer_byte1", got.size() > 1 ? int'(got[1]) : -1, 9'h13C);
    check("xfer_starts", n_start, 1);
    check("xfer_stops", n_stop, 1);
    check("xfer_busy_falls", n_fall, 1);
    // repeated START after 5 bits
    clr();
    start_c(); for (int i = 0; i < 5; i++) bit_c(i[0]);
    start_c(); send_byte(8'h5A, 0); stop_c(); idle(H);
    #2;
    check("rs_nbytes", got.size(), 1);
    check("rs_byte", got.size() > 0 ? int'(got[0]) : -1, 9'h05A);
    check("rs_starts", n_start, 2);
    check("rs_busy_falls", n_fall, 1);
    // SCL held low past the timeout
    clr();
    tmo = 16'd100;
    start_c(); idle(130);
    #2;
    check("tmo_pulses", n_tmo, 1);
    check("tmo_busy", busy_o, 0);
    scl = 1; idle(H); scl = 0; idle(H);
    #2;
    check("tmo_no_byte", n_bv, 0);
    check("tmo_pulses_after", n_tmo, 1);
    stop_c(); tmo = '0; idle(H);
    // enable dropped mid-byte
    start_c(); bit_c(1); bit_c(0); bit_c(1); bit_c(1);
    en = 0;
    clr();
    bit_c(0); bit_c(1); bit_c(0); bit_c(1); bit_c(0); stop_c();
    start_c(); send_byte(8'h77, 0); stop_c();
    #2 check("dis_pulses", n_start + n_stop + n_bv + n_tmo, 0);
    en = 1; idle(H);
    start_c(); send_byte(8'h81, 0); stop_c(); idle(H);
    #2;
    check("en_byte", byte_o, 8'h81);
    check("en_nbytes", n_bv, 1);
    // reset mid-frame
    start_c(); bit_c(1); bit_c(0); bit_c(1);
    clr();
    rst = 1; idle(1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_byte", byte_o, 0);
    check("mid_rst_ack", ack_o, 1);
    rst = 0; idle(1);
    check("post_rst_start", start_o, 0);
    for (int i = 0; i < 6; i++) bit_c(1);
    stop_c(); idle(H);
    #2 check("post_rst_pulses", n_start + n_stop + n_bv + n_tmo, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
